twiddle_seq: RTL and testbench

TWIDDLE_SEQ -- requirements
Module: twiddle_seq

---
 rtl/twiddle_seq.sv | 130 +++++++++++++
 tb/tb_twiddle_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_seq.sv
// twiddle_seq: streams FFT twiddle factors W_N^(k*stride) from a quarter-wave sine table.
// Optional macro TWIDDLE_SEQ_CONJ_EN adds a conj input that negates tw_im (inverse FFT).
module twiddle_seq #(
    parameter int N_LOG2 = 6,
    parameter int W      = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N_LOG2-1:0]     stride,
    input  logic [N_LOG2:0]       count,
`ifdef TWIDDLE_SEQ_CONJ_EN
    input  logic                  conj,
`endif
    output logic                  busy,
    output logic                  tw_valid,
    input  logic                  tw_ready,
    output logic signed [W-1:0]   tw_re,
    output logic signed [W-1:0]   tw_im,
    output logic [N_LOG2-1:0]     tw_idx,
    output logic                  tw_last,
    output logic                  done
);
    localparam int N = 1 << N_LOG2;
    localparam int Q = N / 4;
    localparam int S = 1 << (W - 2);
    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic signed [W-1:0] qsin(input int k);
        real x;
        x = real'(S) * $sin(2.0 * PI * real'(k) / real'(N));
        return W'($rtoi(x + 0.5));
    endfunction

    logic signed [W-1:0] w_tbl [0:Q];
    genvar i;
    for (i = 0; i <= Q; i++) begin : g_tbl
        assign w_tbl[i] = qsin(i);
    end

    state_t              r_state;
    logic [N_LOG2-1:0]   r_stride;
    logic [N_LOG2-1:0]   r_acc;
    logic [N_LOG2:0]     r_rem;
    logic                r_s1_v;
    logic                r_s1_last;
    logic [N_LOG2-1:0]   r_s1_idx;
    logic                w_conj;

`ifdef TWIDDLE_SEQ_CONJ_EN
    logic r_conj;
    always_ff @(posedge clk)
        if (!rst_n)
            r_conj <= 1'b0;
        else if (r_state == IDLE && !busy && start && count != '0)
            r_conj <= conj;
    assign w_conj = r_conj;
`else
    assign w_conj = 1'b0;
`endif

    // Quadrant from the top two index bits; the table covers 0..Q inclusive so Q-r never overflows.
    logic [1:0]          w_q;
    logic [N_LOG2-2:0]   w_r;
    logic [N_LOG2-2:0]   w_rm;
    logic signed [W-1:0] w_a, w_b, w_sin_mag, w_cos_mag, w_re, w_im;
    logic                w_adv, w_fire;

    assign w_q       = r_s1_idx[N_LOG2-1 -: 2];
    assign w_r       = {1'b0, r_s1_idx[N_LOG2-3:0]};
    assign w_rm      = (N_LOG2-1)'(Q) - w_r;
    assign w_a       = w_tbl[w_r];
    assign w_b       = w_tbl[w_rm];
    assign w_sin_mag = w_q[0] ? w_b : w_a;
    assign w_cos_mag = w_q[0] ? w_a : w_b;
    assign w_re      = (w_q[0] ^ w_q[1]) ? -w_cos_mag : w_cos_mag;
    assign w_im      = (w_q[1] ^ w_conj) ? w_sin_mag : -w_sin_mag;
    assign w_adv     = !tw_valid || tw_ready;
    assign w_fire    = tw_valid && tw_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_stride  <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_idx  <= '0;
            busy      <= 1'b0;
            tw_valid  <= 1'b0;
            tw_re     <= '0;
            tw_im     <= '0;
            tw_idx    <= '0;
            tw_last   <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (w_adv) begin
                tw_valid <= r_s1_v;
                tw_re    <= w_re;
                tw_im    <= w_im;
                tw_idx   <= r_s1_idx;
                tw_last  <= r_s1_v && r_s1_last;
                r_s1_v   <= r_state == RUN;
                if (r_state == RUN) begin
                    r_s1_idx  <= r_acc;
                    r_s1_last <= r_rem == (N_LOG2+1)'(1);
                    r_acc     <= r_acc + r_stride;
                    r_rem     <= r_rem - (N_LOG2+1)'(1);
                end
            end
            done <= w_fire && tw_last;
            if (done)
                busy <= 1'b0;
            // busy stays high through the done cycle, so it also blocks a restart there.
            if (r_state == IDLE && !busy && start && count != '0) begin
                r_state  <= RUN;
                busy     <= 1'b1;
                r_stride <= stride;
                r_rem    <= count;
                r_acc    <= '0;
            end else if (r_state == RUN && w_adv && r_rem == (N_LOG2+1)'(1))
                r_state <= DRAIN;
            else if (r_state == DRAIN && w_fire && tw_last)
                r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_twiddle_seq.sv
// tb_twiddle_seq: directed table-driven checks of twiddle_seq plus stall, reset and ignore-start sequences.
module tb_twiddle_seq;
    localparam int N_LOG2 = 6;
    localparam int W      = 10;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                tw_ready = 1'b1;
    logic [N_LOG2-1:0]   stride = '0;
    logic [N_LOG2:0]     count = '0;
    logic                busy, tw_valid, tw_last, done;
    logic signed [W-1:0] tw_re, tw_im;
    logic [N_LOG2-1:0]   tw_idx;
`ifdef TWIDDLE_SEQ_CONJ_EN
    logic                conj = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    twiddle_seq #(.N_LOG2(N_LOG2), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stride(stride), .count(count),
`ifdef TWIDDLE_SEQ_CONJ_EN
        .conj(conj),
`endif
        .busy(busy), .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_re(tw_re), .tw_im(tw_im),
        .tw_idx(tw_idx), .tw_last(tw_last), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stride;
        int count;
        int idx;
        int re;
        int im;
    } vec_t;
    vec_t tv[14];

    int exp_re8[8] = '{256, 255, 251, 245, 237, 226, 213, 198};
    int exp_im8[8] = '{0, -25, -50, -74, -98, -121, -142, -162};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, tw_valid, 0);
        chk({tag, "_last"}, tw_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_re"}, tw_re, 0);
        chk({tag, "_im"}, tw_im, 0);
        chk({tag, "_idx"}, tw_idx, 0);
    endtask

    // Runs the sequence whose beats start at tv[f], tw_ready held high.
    task automatic run_seq(input int f);
        stride = N_LOG2'(tv[f].stride);
        count  = (N_LOG2+1)'(tv[f].count);
        start  = 1'b1;
        tick;
        start  = 1'b0;
        chk($sformatf("s%0d_busy_on", f), busy, 1);
        tick;
        chk($sformatf("s%0d_latency_valid0", f), tw_valid, 0);
        tick;
        for (int k = 0; k < tv[f].count; k++) begin
            if (k > 0) tick;
            chk($sformatf("s%0d_k%0d_valid", f, k), tw_valid, 1);
            chk($sformatf("s%0d_k%0d_idx", f, k), tw_idx, tv[f+k].idx);
            chk($sformatf("s%0d_k%0d_re", f, k), tw_re, tv[f+k].re);
            chk($sformatf("s%0d_k%0d_im", f, k), tw_im, tv[f+k].im);
            chk($sformatf("s%0d_k%0d_last", f, k), tw_last, int'(k == tv[f].count - 1));
        end
        tick;
        chk($sformatf("s%0d_done", f), done, 1);
        chk($sformatf("s%0d_busy_done", f), busy, 1);
        chk($sformatf("s%0d_valid_after", f), tw_valid, 0);
        tick;
        chk($sformatf("s%0d_done_pulse", f), done, 0);
        chk($sformatf("s%0d_busy_off", f), busy, 0);
    endtask

    initial begin
        tv[0]  = '{1, 4, 0, 256, 0};
        tv[1]  = '{1, 4, 1, 255, -25};
        tv[2]  = '{1, 4, 2, 251, -50};
        tv[3]  = '{1, 4, 3, 245, -74};
        tv[4]  = '{16, 4, 0, 256, 0};
        tv[5]  = '{16, 4, 16, 0, -256};
        tv[6]  = '{16, 4, 32, -256, 0};
        tv[7]  = '{16, 4, 48, 0, 256};
        tv[8]  = '{48, 3, 0, 256, 0};
        tv[9]  = '{48, 3, 48, 0, 256};
        tv[10] = '{48, 3, 32, -256, 0};
        tv[11] = '{5, 2, 0, 256, 0};
        tv[12] = '{5, 2, 5, 226, -121};
        tv[13] = '{7, 1, 0, 256, 0};

        // Reset, with start asserted during the reset cycles.
        stride = 6'd1;
        count  = 7'd4;
        start  = 1'b1;
        tick;
        tick;
        chk_zero("reset");
        start = 1'b0;
        rst_n = 1'b1;
        tick;
        chk("reset_start_ignored", busy, 0);
        tick;
        chk("reset_no_valid", tw_valid, 0);

        run_seq(0);
        run_seq(4);
        run_seq(8);
        run_seq(11);
        run_seq(13);

        // count = 0 is ignored.
        stride = 6'd1;
        count  = 7'd0;
        start  = 1'b1;
        tick;
        start = 1'b0;
        chk("cnt0_busy", busy, 0);
        for (int c = 0; c < 4; c++) begin
            tick;
            chk($sformatf("cnt0_valid_c%0d", c), tw_valid, 0);
            chk($sformatf("cnt0_done_c%0d", c), done, 0);
        end

        // start while busy (mid-run and during done) is ignored; input changes do not disturb the run.
        stride = 6'd1;
        count  = 7'd4;
        start  = 1'b1;
        tick;
        stride = 6'd16;
        count  = 7'd2;
        start  = 1'b0;
        tick;
        tick;
        chk("busy_k0_idx", tw_idx, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_k1_idx", tw_idx, 1);
        chk("busy_k1_re", tw_re, 255);
        tick;
        chk("busy_k2_idx", tw_idx, 2);
        chk("busy_k2_im", tw_im, -50);
        tick;
        chk("busy_k3_idx", tw_idx, 3);
        chk("busy_k3_last", tw_last, 1);
        tick;
        chk("busy_done", done, 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_restart_ignored", busy, 0);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk($sformatf("busy_idle_valid_c%0d", c), tw_valid, 0);
        end

        // Alternating backpressure: beats in order, held while stalled, single done.
        begin
            int got = 0;
            int ndone = 0;
            int last_c = -100;
            bit hold = 1'b0;
            int h_idx = 0, h_re = 0, h_im = 0, h_last = 0;
            stride = 6'd1;
            count  = 7'd8;
            start  = 1'b1;
            tick;
            start = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (hold) begin
                    chk($sformatf("stall_hold_valid_c%0d", c), tw_valid, 1);
                    chk($sformatf("stall_hold_idx_c%0d", c), tw_idx, h_idx);
                    chk($sformatf("stall_hold_re_c%0d", c), tw_re, h_re);
                    chk($sformatf("stall_hold_im_c%0d", c), tw_im, h_im);
                    chk($sformatf("stall_hold_last_c%0d", c), tw_last, h_last);
                end
                hold = 1'b0;
                if (done) begin
                    ndone++;
                    chk("stall_done_timing", c, last_c + 1);
                end
                tw_ready = c[0];
                if (tw_valid && tw_ready) begin
                    if (got < 8) begin
                        chk($sformatf("stall_k%0d_idx", got), tw_idx, got);
                        chk($sformatf("stall_k%0d_re", got), tw_re, exp_re8[got]);
                        chk($sformatf("stall_k%0d_im", got), tw_im, exp_im8[got]);
                        chk($sformatf("stall_k%0d_last", got), tw_last, int'(got == 7));
                    end
                    if (tw_last) last_c = c;
                    got++;
                end else if (tw_valid) begin
                    hold   = 1'b1;
                    h_idx  = tw_idx;
                    h_re   = tw_re;
                    h_im   = tw_im;
                    h_last = tw_last;
                end
                tick;
            end
            tw_ready = 1'b1;
            chk("stall_beats", got, 8);
            chk("stall_done_count", ndone, 1);
            chk("stall_busy_off", busy, 0);
        end

        // Reset in the middle of a sequence, then a clean rerun.
        stride = 6'd16;
        count  = 7'd4;
        start  = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        chk("midrst_pre_idx", tw_idx, 16);
        rst_n = 1'b0;
        tick;
        chk_zero("midrst");
        rst_n = 1'b1;
        tick;
        chk("midrst_idle_valid0", tw_valid, 0);
        tick;
        chk("midrst_idle_valid1", tw_valid, 0);
        run_seq(4);

`ifdef TWIDDLE_SEQ_CONJ_EN
        conj   = 1'b1;
        stride = 6'd16;
        count  = 7'd2;
        start  = 1'b1;
        tick;
        start = 1'b0;
        conj  = 1'b0;
        tick;
        tick;
        chk("conj_k0_re", tw_re, 256);
        chk("conj_k0_im", tw_im, 0);
        tick;
        chk("conj_k1_re", tw_re, 0);
        chk("conj_k1_im", tw_im, 256);
        chk("conj_k1_last", tw_last, 1);
        tick;
        chk("conj_done", done, 1);
        tick;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
